fp_align_sequencer: RTL and testbench
=====================================

Name: fp_align_sequencer

Overview:
- Multi-cycle alignment controller for the FP adder front end. Accepts one operand pair through a valid/ready handshake.
- Shifts the smaller-exponent mantissa right by at most SHIFT_STEP bits per cycle, collecting guard, round and sticky bits.
- Presents the aligned mantissas and output exponent to the add stage through a second valid/ready handshake.
- Replaces the single-cycle barrel shift with a small, timing-friendly iterative shifter.

Parameters:
- SHIFT_STEP, 4, bits shifted per SHIFT cycle. Legal values 1, 2, 4 or 8.
- MAX_SHIFT, 26, exponent differential at or above which the smaller operand collapses entirely into sticky.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort, returns to IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  high only in IDLE
- signA, signB  in  1 each  operand signs
- exponentA, exponentB  in  8 each  biased exponents
- mantissaA, mantissaB  in  23 each  fraction fields
- out_valid  out  1  aligned result valid (DONE state)
- out_ready  in  1  downstream accepts the result
- signAOut, signBOut  out  1 each  registered signs
- exponentOut  out  8  result exponent
- alignedMantissaA, alignedMantissaB  out  24 each  aligned mantissas in A/B position; no swapping
- guardBit, roundBit, stickyBit  out  1 each  rounding bits of the shifted operand
- specialCase  out  2  00 normal, 01 zero/subnormal involved, 10 Inf/NaN involved
- busy  out  1  state is not IDLE

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low. Reset puts the FSM in IDLE and clears every registered output to 0. in_ready = 1 while in reset, since it decodes IDLE; no transfer is accepted while rst_n is low.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, on in_valid && in_ready: register signs, classify operands, compute diff.
  - Either exponent == FF:
    - exponentOut = FF, specialCase = 10, GRS = 000.
    - Each FF operand's mantissa = {0, frac}; the other operand's mantissa = {1, frac}.
    - If both exponents are FF, both mantissas = {0, frac}.
    - Go to DONE.
  - Else either exponent == 0: specialCase = 01.
    - Both exponents zero: exponentOut = 0, both mantissas = {0, frac}, GRS = 000, go to DONE.
    - One exponent zero: exponentOut = the other operand's exponent. The zero-exponent operand uses extended {0, frac, 2'b0}. diff = exponentOut. Shift it as in the normal case.
  - Else (normal): extended = {1, frac, 2'b0} (26 bits). The larger-exponent operand is passed through unshifted and exponentOut = its exponent. Ties: no shift, diff = 0. diff = |exponentA − exponentB| (8-bit unsigned).
  - diff == 0: go to DONE.
  - diff >= MAX_SHIFT: shifted operand = 0, GRS = {0, 0, |extended}, go to DONE.
  - Otherwise: load a 26-bit shift register, remaining = diff, sticky = 0, go to SHIFT.
- SHIFT, each cycle:
  - n = min(SHIFT_STEP, remaining).
  - sticky |= OR of the n bits shifted out.
  - Shift register >>= n; remaining −= n.
  - When remaining reaches 0, go to DONE.
  - On entering DONE: aligned mantissa = register[25:2], guardBit = [1], roundBit = [0], stickyBit = accumulated sticky.
- Latency, counted from the accept edge to out_valid high:
  - 1 cycle when no shift is needed (special case, diff = 0, or diff >= MAX_SHIFT).
  - 1 + ceil(diff / SHIFT_STEP) cycles otherwise.
- DONE:
  - out_valid = 1; all outputs stable while out_ready = 0.
  - out_valid && out_ready: go to IDLE; out_valid low next cycle.
  - No same-cycle acceptance: in_ready is low in DONE.
- flush: from any state, next edge → IDLE, out_valid = 0, result registers cleared. flush has priority over both handshakes in the same cycle.
- Inputs are sampled only on accept. Changing inputs during SHIFT or DONE has no effect.

Optional Feature:
- Macro ALIGN_PERF_CNT_EN.
- Defined: adds output port alignCycleCount [15:0], a saturating count of cycles spent in SHIFT, and output port alignOpCount [15:0], a saturating count of completed output handshakes. Both are cleared only by rst_n; flush does not clear them.
- Undefined: neither port nor counter logic exists.

Test Plan:
- 1.0 (3F800000) + 0.5 (3F000000), SHIFT_STEP = 4:
  - exponentOut = 7F, alignedMantissaA = 800000, alignedMantissaB = 400000, GRS = 000, specialCase = 00.
  - out_valid 2 cycles after accept.
- A = 3F800000, B = {0, 75, 000001}, diff 10:
  - alignedMantissaB = 002000, guardBit = 0, roundBit = 0, stickyBit = 1.
  - out_valid 4 cycles after accept.
- A exp 9F, B exp 7F (diff 32):
  - alignedMantissaB = 000000, GRS = 001, exponentOut = 9F.
  - out_valid 1 cycle after accept.
- A = 7F800000 (+Inf), B = 3F800000:
  - specialCase = 10, exponentOut = FF, alignedMantissaA = 000000, alignedMantissaB = 800000, GRS = 000.
  - 1-cycle latency.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE:
  - Outputs constant, in_ready = 0, busy = 1.
  - Raise out_ready: IDLE next cycle, in_ready = 1.
- Pulse flush on the 2nd SHIFT cycle of a diff-20 operation:
  - out_valid never asserts; IDLE next cycle.
  - The following 1.0 + 0.5 operation completes exactly as in scenario 1.
- Assert rst_n low mid-SHIFT:
  - All outputs 0 immediately (asynchronous); state is IDLE on release.

Source files
------------

// File: rtl/fp_align_sequencer.sv
// Iterative mantissa alignment front end for the FP adder: accepts an operand pair,
// shifts the smaller-exponent mantissa SHIFT_STEP bits per cycle and collects G/R/S.
// Optional performance counters are enabled with `define ALIGN_PERF_CNT_EN.
module fp_align_sequencer #(
    parameter int SHIFT_STEP = 4,
    parameter int MAX_SHIFT  = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        signA,
    input  logic        signB,
    input  logic [7:0]  exponentA,
    input  logic [7:0]  exponentB,
    input  logic [22:0] mantissaA,
    input  logic [22:0] mantissaB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        signAOut,
    output logic        signBOut,
    output logic [7:0]  exponentOut,
    output logic [23:0] alignedMantissaA,
    output logic [23:0] alignedMantissaB,
    output logic        guardBit,
    output logic        roundBit,
    output logic        stickyBit,
    output logic [1:0]  specialCase,
    output logic        busy
`ifdef ALIGN_PERF_CNT_EN
    ,
    output logic [15:0] alignCycleCount,
    output logic [15:0] alignOpCount
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] STEP_L    = 8'(SHIFT_STEP);
    localparam logic [7:0] MAX_SHIFT_L = 8'(MAX_SHIFT);

    // Extended mantissa: hidden bit, fraction, two guard/round positions.
    function automatic logic [25:0] f_extend(input logic exp_zero, input logic [22:0] frac);
        f_extend = {~exp_zero, frac, 2'b00};
    endfunction

    function automatic logic [7:0] f_min8(input logic [7:0] a, input logic [7:0] b);
        f_min8 = (a < b) ? a : b;
    endfunction

    state_t      state_q, state_d;
    logic [25:0] shreg_q, shreg_d;
    logic [7:0]  rem_q, rem_d;
    logic        acc_q, acc_d;
    logic        shift_b_q, shift_b_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic [7:0]  exp_q, exp_d;
    logic [23:0] mant_a_q, mant_a_d;
    logic [23:0] mant_b_q, mant_b_d;
    logic        guard_q, guard_d;
    logic        round_q, round_d;
    logic        sticky_q, sticky_d;
    logic [1:0]  special_q, special_d;
    logic        out_valid_q, out_valid_d;

    logic        a_ff_s, b_ff_s, a_zero_s, b_zero_s, shift_b_s;
    logic [25:0] ext_a_s, ext_b_s, small_ext_s;
    logic [23:0] pass_mant_s;
    logic [7:0]  diff_s, big_exp_s;
    logic [7:0]  step_n_s, rem_nxt_s;
    logic [25:0] mask_s, shreg_nxt_s;
    logic        acc_nxt_s;

    assign a_ff_s    = (exponentA == 8'hFF);
    assign b_ff_s    = (exponentB == 8'hFF);
    assign a_zero_s  = (exponentA == 8'h00);
    assign b_zero_s  = (exponentB == 8'h00);
    // B is the shifted operand whenever A's exponent is at least as large (ties shift nothing).
    assign shift_b_s = (exponentA >= exponentB);
    assign diff_s    = shift_b_s ? (exponentA - exponentB) : (exponentB - exponentA);
    assign big_exp_s = shift_b_s ? exponentA : exponentB;
    assign ext_a_s   = f_extend(a_zero_s, mantissaA);
    assign ext_b_s   = f_extend(b_zero_s, mantissaB);
    assign small_ext_s = shift_b_s ? ext_b_s : ext_a_s;
    assign pass_mant_s = shift_b_s ? ext_a_s[25:2] : ext_b_s[25:2];

    assign step_n_s    = f_min8(STEP_L, rem_q);
    assign mask_s      = (26'd1 << step_n_s) - 26'd1;
    assign shreg_nxt_s = shreg_q >> step_n_s;
    assign acc_nxt_s   = acc_q | (|(shreg_q & mask_s));
    assign rem_nxt_s   = rem_q - step_n_s;

    // Next-state and next-result computation for the alignment FSM.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        shift_b_d   = shift_b_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        exp_d       = exp_q;
        mant_a_d    = mant_a_q;
        mant_b_d    = mant_b_q;
        guard_d     = guard_q;
        round_d     = round_q;
        sticky_d    = sticky_q;
        special_d   = special_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            state_d     = ST_IDLE;
            shreg_d     = 26'd0;
            rem_d       = 8'd0;
            acc_d       = 1'b0;
            shift_b_d   = 1'b0;
            sign_a_d    = 1'b0;
            sign_b_d    = 1'b0;
            exp_d       = 8'd0;
            mant_a_d    = 24'd0;
            mant_b_d    = 24'd0;
            guard_d     = 1'b0;
            round_d     = 1'b0;
            sticky_d    = 1'b0;
            special_d   = 2'b00;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_a_d = signA;
                        sign_b_d = signB;
                        guard_d  = 1'b0;
                        round_d  = 1'b0;
                        sticky_d = 1'b0;
                        if (a_ff_s || b_ff_s) begin
                            exp_d       = 8'hFF;
                            special_d   = 2'b10;
                            mant_a_d    = {~a_ff_s, mantissaA};
                            mant_b_d    = {~b_ff_s, mantissaB};
                            state_d     = ST_DONE;
                            out_valid_d = 1'b1;
                        end else if (a_zero_s && b_zero_s) begin
                            exp_d       = 8'h00;
                            special_d   = 2'b01;
                            mant_a_d    = {1'b0, mantissaA};
                            mant_b_d    = {1'b0, mantissaB};
                            state_d     = ST_DONE;
                            out_valid_d = 1'b1;
                        end else begin
                            special_d = (a_zero_s || b_zero_s) ? 2'b01 : 2'b00;
                            exp_d     = big_exp_s;
                            shift_b_d = shift_b_s;
                            if (diff_s == 8'd0) begin
                                mant_a_d    = ext_a_s[25:2];
                                mant_b_d    = ext_b_s[25:2];
                                state_d     = ST_DONE;
                                out_valid_d = 1'b1;
                            end else begin
                                if (shift_b_s) begin
                                    mant_a_d = pass_mant_s;
                                    mant_b_d = 24'd0;
                                end else begin
                                    mant_a_d = 24'd0;
                                    mant_b_d = pass_mant_s;
                                end
                                if (diff_s >= MAX_SHIFT_L) begin
                                    sticky_d    = |small_ext_s;
                                    state_d     = ST_DONE;
                                    out_valid_d = 1'b1;
                                end else begin
                                    shreg_d = small_ext_s;
                                    rem_d   = diff_s;
                                    acc_d   = 1'b0;
                                    state_d = ST_SHIFT;
                                end
                            end
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    shreg_d = shreg_nxt_s;
                    rem_d   = rem_nxt_s;
                    acc_d   = acc_nxt_s;
                    if (rem_nxt_s == 8'd0) begin
                        if (shift_b_q) begin
                            mant_b_d = shreg_nxt_s[25:2];
                        end else begin
                            mant_a_d = shreg_nxt_s[25:2];
                        end
                        guard_d     = shreg_nxt_s[1];
                        round_d     = shreg_nxt_s[0];
                        sticky_d    = acc_nxt_s;
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= 26'd0;
            rem_q       <= 8'd0;
            acc_q       <= 1'b0;
            shift_b_q   <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            exp_q       <= 8'd0;
            mant_a_q    <= 24'd0;
            mant_b_q    <= 24'd0;
            guard_q     <= 1'b0;
            round_q     <= 1'b0;
            sticky_q    <= 1'b0;
            special_q   <= 2'b00;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            shift_b_q   <= shift_b_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            exp_q       <= exp_d;
            mant_a_q    <= mant_a_d;
            mant_b_q    <= mant_b_d;
            guard_q     <= guard_d;
            round_q     <= round_d;
            sticky_q    <= sticky_d;
            special_q   <= special_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready         = (state_q == ST_IDLE);
    assign busy             = (state_q != ST_IDLE);
    assign out_valid        = out_valid_q;
    assign signAOut         = sign_a_q;
    assign signBOut         = sign_b_q;
    assign exponentOut      = exp_q;
    assign alignedMantissaA = mant_a_q;
    assign alignedMantissaB = mant_b_q;
    assign guardBit         = guard_q;
    assign roundBit         = round_q;
    assign stickyBit        = sticky_q;
    assign specialCase      = special_q;

`ifdef ALIGN_PERF_CNT_EN
    logic [15:0] cyc_cnt_q, cyc_cnt_d;
    logic [15:0] op_cnt_q, op_cnt_d;

    // Saturating counters; flush deliberately leaves them untouched.
    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        op_cnt_d  = op_cnt_q;
        if ((state_q == ST_SHIFT) && (cyc_cnt_q != 16'hFFFF)) begin
            cyc_cnt_d = cyc_cnt_q + 16'd1;
        end else begin
            cyc_cnt_d = cyc_cnt_q;
        end
        if ((state_q == ST_DONE) && out_ready && !flush && (op_cnt_q != 16'hFFFF)) begin
            op_cnt_d = op_cnt_q + 16'd1;
        end else begin
            op_cnt_d = op_cnt_q;
        end
    end

    // Counter registers, cleared only by the hardware reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt_q <= 16'd0;
            op_cnt_q  <= 16'd0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            op_cnt_q  <= op_cnt_d;
        end
    end

    assign alignCycleCount = cyc_cnt_q;
    assign alignOpCount    = op_cnt_q;
`endif

endmodule

// File: tb/tb_fp_align_sequencer.sv
// Directed scoreboard bench for fp_align_sequencer (default parameters, SHIFT_STEP = 4).
module tb_fp_align_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        signA = 1'b0, signB = 1'b0;
    logic [7:0]  exponentA = 8'd0, exponentB = 8'd0;
    logic [22:0] mantissaA = 23'd0, mantissaB = 23'd0;
    logic        in_ready, out_valid, signAOut, signBOut;
    logic [7:0]  exponentOut;
    logic [23:0] alignedMantissaA, alignedMantissaB;
    logic        guardBit, roundBit, stickyBit, busy;
    logic [1:0]  specialCase;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sa;
        logic        sb;
        logic [7:0]  ex;
        logic [23:0] ma;
        logic [23:0] mb;
        logic [2:0]  grs;
        logic [1:0]  sp;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    fp_align_sequencer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .signA(signA), .signB(signB),
        .exponentA(exponentA), .exponentB(exponentB),
        .mantissaA(mantissaA), .mantissaB(mantissaB),
        .out_valid(out_valid), .out_ready(out_ready),
        .signAOut(signAOut), .signBOut(signBOut),
        .exponentOut(exponentOut),
        .alignedMantissaA(alignedMantissaA), .alignedMantissaB(alignedMantissaB),
        .guardBit(guardBit), .roundBit(roundBit), .stickyBit(stickyBit),
        .specialCase(specialCase), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic sa, input logic sb, input logic [7:0] ex,
                                input logic [23:0] ma, input logic [23:0] mb,
                                input logic [2:0] grs, input logic [1:0] sp, input int lat);
        exp_t e;
        e.sa = sa; e.sb = sb; e.ex = ex; e.ma = ma; e.mb = mb;
        e.grs = grs; e.sp = sp; e.lat = lat;
        return e;
    endfunction

    task automatic drive(input logic sa, input logic [7:0] ea, input logic [22:0] fa,
                         input logic sb, input logic [7:0] eb, input logic [22:0] fb);
        signA = sa; exponentA = ea; mantissaA = fa;
        signB = sb; exponentB = eb; mantissaB = fb;
        in_valid = 1'b1;
    endtask

    task automatic scramble();
        in_valid  = 1'b0;
        signA     = ~signA;
        signB     = ~signB;
        exponentA = 8'h55;
        exponentB = 8'hC3;
        mantissaA = 23'h2AAAAA;
        mantissaB = 23'h155555;
    endtask

    task automatic check_result(input string tag, input exp_t g);
        check({tag, ".exp"}, 32'(exponentOut), 32'(g.ex));
        check({tag, ".ma"}, 32'(alignedMantissaA), 32'(g.ma));
        check({tag, ".mb"}, 32'(alignedMantissaB), 32'(g.mb));
        check({tag, ".grs"}, 32'({guardBit, roundBit, stickyBit}), 32'(g.grs));
        check({tag, ".sp"}, 32'(specialCase), 32'(g.sp));
        check({tag, ".signs"}, 32'({signAOut, signBOut}), 32'({g.sa, g.sb}));
    endtask

    task automatic run_op(input string tag,
                          input logic sa, input logic [7:0] ea, input logic [22:0] fa,
                          input logic sb, input logic [7:0] eb, input logic [22:0] fb,
                          input exp_t e, input int hold);
        int   cyc;
        exp_t g;
        sb_q.push_back(e);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        drive(sa, ea, fa, sb, eb, fb);
        step();
        scramble();
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 64) begin
            step();
            cyc++;
        end
        g = sb_q.pop_front();
        check({tag, ".latency"}, 32'(cyc), 32'(g.lat));
        check_result(tag, g);
        for (int i = 0; i < hold; i++) begin
            step();
            check_result({tag, ".hold"}, g);
            check({tag, ".hold.in_ready"}, 32'(in_ready), 32'd0);
            check({tag, ".hold.busy"}, 32'(busy), 32'd1);
            check({tag, ".hold.out_valid"}, 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ".post.out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".post.in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Reset state, observed before the first clock edge.
        #3;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.exp", 32'(exponentOut), 32'd0);
        check("rst.ma", 32'(alignedMantissaA), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_op("one_plus_half", 1'b0, 8'h7F, 23'h0, 1'b0, 8'h7E, 23'h0,
               mk(1'b0, 1'b0, 8'h7F, 24'h800000, 24'h400000, 3'b000, 2'b00, 2), 0);
        run_op("diff10", 1'b0, 8'h7F, 23'h0, 1'b1, 8'h75, 23'h000001,
               mk(1'b0, 1'b1, 8'h7F, 24'h800000, 24'h002000, 3'b001, 2'b00, 4), 0);
        run_op("diff32", 1'b1, 8'h9F, 23'h0, 1'b0, 8'h7F, 23'h0,
               mk(1'b1, 1'b0, 8'h9F, 24'h800000, 24'h000000, 3'b001, 2'b00, 1), 0);
        run_op("inf", 1'b0, 8'hFF, 23'h0, 1'b0, 8'h7F, 23'h0,
               mk(1'b0, 1'b0, 8'hFF, 24'h000000, 24'h800000, 3'b000, 2'b10, 1), 0);
        run_op("diff8_grs", 1'b0, 8'h88, 23'h0, 1'b0, 8'h80, 23'h7FFFFF,
               mk(1'b0, 1'b0, 8'h88, 24'h800000, 24'h00FFFF, 3'b111, 2'b00, 3), 0);
        run_op("diff25_a", 1'b0, 8'h80, 23'h0, 1'b0, 8'h99, 23'h0,
               mk(1'b0, 1'b0, 8'h99, 24'h000000, 24'h800000, 3'b010, 2'b00, 8), 0);
        run_op("diff26_a", 1'b0, 8'h80, 23'h0, 1'b0, 8'h9A, 23'h0,
               mk(1'b0, 1'b0, 8'h9A, 24'h000000, 24'h800000, 3'b001, 2'b00, 1), 0);
        run_op("subnormal_a", 1'b0, 8'h00, 23'h400000, 1'b0, 8'h02, 23'h0,
               mk(1'b0, 1'b0, 8'h02, 24'h100000, 24'h800000, 3'b000, 2'b01, 2), 0);
        run_op("both_zero", 1'b0, 8'h00, 23'h000001, 1'b1, 8'h00, 23'h0,
               mk(1'b0, 1'b1, 8'h00, 24'h000001, 24'h000000, 3'b000, 2'b01, 1), 0);
        run_op("backpressure", 1'b0, 8'h80, 23'h0, 1'b0, 8'h80, 23'h0,
               mk(1'b0, 1'b0, 8'h80, 24'h800000, 24'h800000, 3'b000, 2'b00, 1), 5);

        // Flush on the second SHIFT cycle of a diff-20 operation.
        drive(1'b0, 8'h94, 23'h0, 1'b0, 8'h80, 23'h0);
        step();
        scramble();
        check("flush.busy_shift", 32'(busy), 32'd1);
        step();
        flush = 1'b1;
        check("flush.out_valid_pre", 32'(out_valid), 32'd0);
        step();
        flush = 1'b0;
        check("flush.in_ready", 32'(in_ready), 32'd1);
        check("flush.busy", 32'(busy), 32'd0);
        check("flush.exp", 32'(exponentOut), 32'd0);
        check("flush.ma", 32'(alignedMantissaA), 32'd0);
        for (int i = 0; i < 6; i++) begin
            check("flush.out_valid_after", 32'(out_valid), 32'd0);
            step();
        end
        run_op("after_flush", 1'b0, 8'h7F, 23'h0, 1'b0, 8'h7E, 23'h0,
               mk(1'b0, 1'b0, 8'h7F, 24'h800000, 24'h400000, 3'b000, 2'b00, 2), 0);

        // Asynchronous reset in the middle of SHIFT.
        drive(1'b1, 8'h94, 23'h0, 1'b0, 8'h80, 23'h0);
        step();
        scramble();
        check("arst.busy_shift", 32'(busy), 32'd1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.exp", 32'(exponentOut), 32'd0);
        check("arst.ma", 32'(alignedMantissaA), 32'd0);
        check("arst.signA", 32'(signAOut), 32'd0);
        check("arst.out_valid", 32'(out_valid), 32'd0);
        check("arst.busy", 32'(busy), 32'd0);
        check("arst.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("arst.release_busy", 32'(busy), 32'd0);
        check("arst.release_in_ready", 32'(in_ready), 32'd1);
        run_op("after_reset", 1'b0, 8'h7F, 23'h0, 1'b0, 8'h7E, 23'h0,
               mk(1'b0, 1'b0, 8'h7F, 24'h800000, 24'h400000, 3'b000, 2'b00, 2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
